// File: rtl/lock_cfg_writer_if.sv
// Bundle between a config source, the writer and the lockable register.
// Carries the entry handshake, the register write/lock port and status.
interface lock_cfg_writer_if #(
   parameter int DATA_W = 8
);
   logic              cfg_valid;
   logic [DATA_W-1:0] cfg_data;
   logic              cfg_lock;
   logic              cfg_ready;
   logic              err_clr;
   logic              reg_wr_en;
   logic [DATA_W-1:0] reg_data;
   logic              reg_lock_en;
   logic [DATA_W-1:0] reg_rdata;
   logic              busy;
   logic              locked;
   logic              error;
   logic [1:0]        retry_cnt;

   modport master (
      output cfg_valid, cfg_data, cfg_lock, err_clr, reg_rdata,
      input  cfg_ready, reg_wr_en, reg_data, reg_lock_en,
      input  busy, locked, error, retry_cnt
   );

   modport slave (
      input  cfg_valid, cfg_data, cfg_lock, err_clr, reg_rdata,
      output cfg_ready, reg_wr_en, reg_data, reg_lock_en,
      output busy, locked, error, retry_cnt
   );
endinterface

// File: rtl/lock_cfg_writer.sv
// Writes one config entry to a lockable register, verifies it by readback,
// retries on mismatch and optionally locks the register afterwards.
// Ports: clk, rst_n (async, active-high), bus (slave side of
// lock_cfg_writer_if: cfg handshake, err_clr, register port, status).
module lock_cfg_writer #(
   parameter int DATA_W      = 8,
   parameter int VERIFY_WAIT = 2,
   parameter int MAX_RETRY   = 3
) (
   input logic              clk,
   input logic              rst_n,
   lock_cfg_writer_if.slave bus
);

   localparam int WCW = (VERIFY_WAIT > 1) ? $clog2(VERIFY_WAIT) : 1;
   localparam logic [WCW-1:0] W_LOAD = WCW'(VERIFY_WAIT - 1);
   localparam logic [1:0] MAX_R = 2'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WAIT,
      S_LOCK,
      S_LOCKED,
      S_ERROR
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              lock_q, lock_d;
   logic [1:0]        retry_q, retry_d;
   logic [WCW-1:0]    wcnt_q, wcnt_d;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         lock_q  <= 1'b0;
         retry_q <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         lock_q  <= lock_d;
         retry_q <= retry_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      lock_d  = lock_q;
      retry_d = retry_q;
      wcnt_d  = wcnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.cfg_valid) begin
               data_d  = bus.cfg_data;
               lock_d  = bus.cfg_lock;
               retry_d = '0;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            wcnt_d  = W_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Readback is only trusted in the final wait cycle.
            if (wcnt_q != '0) begin
               wcnt_d = wcnt_q - 1'b1;
            end else if (bus.reg_rdata == data_q) begin
               state_d = lock_q ? S_LOCK : S_IDLE;
            end else if (retry_q < MAX_R) begin
               retry_d = retry_q + 1'b1;
               state_d = S_WRITE;
            end else begin
               state_d = S_ERROR;
            end
         end
         S_LOCK:   state_d = S_LOCKED;
         S_LOCKED: state_d = S_LOCKED;
         S_ERROR: begin
            // cfg_ready is low here, so a pending entry waits for IDLE.
            if (bus.err_clr) state_d = S_IDLE;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs decode state or registers only; no input reaches an output.
   assign bus.cfg_ready   = (state_q == S_IDLE);
   assign bus.reg_wr_en   = (state_q == S_WRITE);
   assign bus.reg_data    = data_q;
   assign bus.reg_lock_en = (state_q == S_LOCK) || (state_q == S_LOCKED);
   assign bus.busy        = (state_q == S_WRITE) || (state_q == S_WAIT) ||
                            (state_q == S_LOCK);
   assign bus.locked      = (state_q == S_LOCKED);
   assign bus.error       = (state_q == S_ERROR);
   assign bus.retry_cnt   = retry_q;

endmodule

// File: doc/lock_cfg_writer.md
LOCK_CFG_WRITER -- requirements
Module: lock_cfg_writer

Interface
REQ-001 Parameter DATA_W, default 8: width of the configuration data and register data paths.
REQ-002 Parameter VERIFY_WAIT, default 2: number of cycles (>=1) between a register write and its readback compare.
REQ-003 Parameter MAX_RETRY, default 3: number of rewrites (1..3) allowed after a readback mismatch before the block enters ERROR.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-high reset (the block is in reset while rst_n=1).
REQ-006 cfg_valid  input  1  a configuration entry is offered.
REQ-007 cfg_data  input  DATA_W  configuration value to program.
REQ-008 cfg_lock  input  1  lock the target register after this entry verifies.
REQ-009 cfg_ready  output  1  block accepts an entry; a handshake occurs when cfg_valid=1 and cfg_ready=1 at a rising edge.
REQ-010 err_clr  input  1  clears the ERROR state.
REQ-011 reg_wr_en  output  1  write strobe to the lockable register.
REQ-012 reg_data  output  DATA_W  write data to the lockable register.
REQ-013 reg_lock_en  output  1  lock request to the lockable register.
REQ-014 reg_rdata  input  DATA_W  current output value of the lockable register.
REQ-015 busy  output  1  high in every state except IDLE, LOCKED and ERROR.
REQ-016 locked  output  1  high in LOCKED.
REQ-017 error  output  1  high in ERROR.
REQ-018 retry_cnt  output  2  number of rewrites performed for the current entry.

Function
REQ-019 The FSM SHALL have the states IDLE, WRITE, WAIT, LOCK, LOCKED and ERROR; all outputs are registered or decoded from the state only, with no combinational path from any input to any output.
REQ-020 IDLE: cfg_ready=1; on a handshake, capture cfg_data and cfg_lock, clear retry_cnt, and go to WRITE.
REQ-021 WRITE: exactly one cycle; reg_wr_en=1 and reg_data=captured value; then go to WAIT and load the wait counter with VERIFY_WAIT-1.
REQ-022 WAIT: hold for exactly VERIFY_WAIT cycles; in the last WAIT cycle, compare reg_rdata with the captured value.
REQ-023 On a match, go to LOCK if the captured cfg_lock=1; otherwise go to IDLE.
REQ-024 On a mismatch with retry_cnt<MAX_RETRY, increment retry_cnt and go to WRITE; with retry_cnt=MAX_RETRY, go to ERROR.
REQ-025 LOCK: exactly one cycle with reg_lock_en=1; then go to LOCKED.
REQ-026 LOCKED: reg_lock_en=1 and cfg_ready=0, held permanently until reset; err_clr and cfg_valid are ignored.
REQ-027 ERROR: cfg_ready=0 and error=1; err_clr=1 returns to IDLE on the next edge; retry_cnt holds its value until the next handshake.
REQ-028 reg_data SHALL hold the last captured value in every state; reg_wr_en SHALL be 1 only in WRITE.
REQ-029 Timing with VERIFY_WAIT=2 and a handshake at edge T: WRITE in cycle T+1, WAIT in cycles T+2 and T+3, IDLE (cfg_ready=1) or LOCK in cycle T+4, LOCKED from cycle T+5.
REQ-030 cfg_valid while cfg_ready=0 SHALL be ignored; the source holds its entry until cfg_ready=1.
REQ-031 Simultaneous err_clr=1 and cfg_valid=1 in ERROR SHALL return to IDLE only; the entry is accepted no earlier than the following cycle.

Reset
REQ-032 While rst_n=1, the block SHALL immediately, without waiting for clk, force state=IDLE, cfg_ready=1 (combinationally), reg_wr_en=0, reg_lock_en=0, reg_data=0, busy=0, locked=0, error=0, retry_cnt=0, and clear the wait counter.
REQ-033 Reset asserted in any state, including WRITE, WAIT or LOCKED, SHALL abandon the current entry; the first handshake is accepted on the first rising edge after rst_n falls.

Verification
REQ-034 Handshake with cfg_data=8'hA5, cfg_lock=0, reg_rdata tracking writes -> reg_wr_en=1 for one cycle with reg_data=8'hA5; cfg_ready=1 again 4 cycles after the handshake; retry_cnt=0.
REQ-035 cfg_data=8'h3C, cfg_lock=1 -> reg_lock_en rises one cycle after the verify and stays 1; locked=1; a later cfg_valid is never accepted.
REQ-036 reg_rdata stuck at 8'h00, cfg_data=8'h55, MAX_RETRY=3 -> exactly 4 reg_wr_en pulses, then error=1 and retry_cnt=3; err_clr=1 -> IDLE with cfg_ready=1.
REQ-037 reg_rdata wrong on the first compare and correct on the second -> exactly 2 write pulses, retry_cnt=1, return to IDLE, error=0.
REQ-038 rst_n pulsed high during WAIT -> all outputs at their reset values before the next clk edge; a new entry 8'h0F completes normally after reset.
REQ-039 ERROR state with err_clr=1 and cfg_valid=1 in the same cycle -> IDLE only, no write; the entry is accepted on the next edge.
